memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 156 +++++++++++++++
 tb/tb_memory_access.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage with a req/gnt/rvalid data bus, load formatting and the MEM/WB register.
package memory_access_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_oper_t;
endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  mem_oper_t   mem_oper_i,
  input  logic        trap_i,
  input  logic        wb_use_mem_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_busy_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic        wb_use_mem_o,
  output logic        write_rd_o,
  output logic        trap_o,
  output logic [4:0]  rd_addr_o
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DONE} state_t;
  state_t      state_q, state_d;
  logic        is_store, misalign, access, upd, clr;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, lane_w, fmt_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  mem_oper_t   op_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] alu_q, alu_d, data_q, data_d;
  logic        wbm_q, wbm_d, wr_q, wr_d, trap_q, trap_d;
  logic [4:0]  rd_q, rd_d;
  always_comb begin
    off      = alu_result_i[1:0];
    is_store = mem_oper_i inside {MEM_SB, MEM_SH, MEM_SW};
    misalign = ((mem_oper_i inside {MEM_LH, MEM_LHU, MEM_SH}) && off[0]) ||
               ((mem_oper_i inside {MEM_LW, MEM_SW}) && off != 2'b00);
    access   = mem_oper_i != MEM_NOP && !trap_i && !misalign;
    be_c     = mem_oper_i == MEM_SB ? 4'b0001 << off :
               mem_oper_i == MEM_SH ? 4'b0011 << off : 4'b1111;
    wdata_c  = mem_oper_i == MEM_SB ? {4{alu_oper2_i[7:0]}} :
               mem_oper_i == MEM_SH ? {2{alu_oper2_i[15:0]}} : alu_oper2_i;
  end
  // While waiting for grant the bus fields come from the issue-time copy so they stay stable.
  always_comb begin
    dmem_req_o   = (state_q == IDLE && access) || state_q == WAIT_GNT;
    dmem_we_o    = state_q == IDLE ? is_store : we_q;
    dmem_be_o    = state_q == IDLE ? be_c : be_q;
    dmem_addr_o  = state_q == IDLE ? {alu_result_i[31:2], 2'b00} : addr_q;
    dmem_wdata_o = state_q == IDLE ? wdata_c : wdata_q;
    mem_busy_o   = (state_q == IDLE && access) || state_q == WAIT_GNT ||
                   (state_q == WAIT_RVALID && !dmem_rvalid_i);
  end
  always_comb begin
    lane_w = dmem_rdata_i >> {off_q, 3'b000};
    byte_c = lane_w[7:0];
    half_c = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    fmt_c  = op_q == MEM_LB  ? {{24{byte_c[7]}}, byte_c} :
             op_q == MEM_LBU ? {24'b0, byte_c} :
             op_q == MEM_LH  ? {{16{half_c[15]}}, half_c} :
             op_q == MEM_LHU ? {16'b0, half_c} :
             op_q == MEM_LW  ? dmem_rdata_i : 32'b0;
  end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:        state_d = access ? (dmem_gnt_i ? WAIT_RVALID : WAIT_GNT) : IDLE;
      WAIT_GNT:    state_d = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
      WAIT_RVALID: begin
        state_d = dmem_rvalid_i ? (stall_i ? DONE : IDLE) : WAIT_RVALID;
        hold_d  = dmem_rvalid_i && stall_i ? fmt_c : hold_q;
      end
      default:     state_d = stall_i ? DONE : IDLE;
    endcase
    kill_d = state_d == IDLE ? 1'b0 : (kill_q || (flush_i && state_q != IDLE));
  end
  // A flushed transaction still drains on the bus, but retires as an all-zero bubble.
  always_comb begin
    upd    = !stall_i && !mem_busy_o;
    clr    = flush_i || (upd && kill_q && state_q != IDLE);
    alu_d  = clr ? 32'b0 : upd ? alu_result_i : alu_q;
    data_d = clr ? 32'b0 : !upd ? data_q :
             state_q == DONE ? hold_q : state_q == WAIT_RVALID ? fmt_c : 32'b0;
    wbm_d  = clr ? 1'b0 : upd ? wb_use_mem_i : wbm_q;
    wr_d   = clr ? 1'b0 : upd ? write_rd_i && !misalign : wr_q;
    rd_d   = clr ? 5'b0 : upd ? rd_addr_i : rd_q;
    trap_d = clr ? 1'b0 : upd ? trap_i || misalign : trap_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      hold_q  <= 32'b0;
      alu_q   <= 32'b0;
      data_q  <= 32'b0;
      wbm_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 5'b0;
      trap_q  <= 1'b0;
      op_q    <= MEM_NOP;
      off_q   <= 2'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      wbm_q   <= wbm_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      trap_q  <= trap_d;
      if (state_q == IDLE && access) begin
        op_q    <= mem_oper_i;
        off_q   <= off;
        we_q    <= is_store;
        be_q    <= be_c;
        addr_q  <= {alu_result_i[31:2], 2'b00};
        wdata_q <= wdata_c;
      end
    end
  end
  assign alu_result_o = alu_q;
  assign mem_data_o   = data_q;
  assign wb_use_mem_o = wbm_q;
  assign write_rd_o   = wr_q;
  assign rd_addr_o    = rd_q;
  assign trap_o       = trap_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table plus hand-written stall, flush and reset sequences.
module tb_memory_access;
  import memory_access_pkg::*;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic [31:0] alu_result_i = '0, alu_oper2_i = '0, dmem_rdata_i = '0;
  mem_oper_t   mem_oper_i = MEM_NOP;
  logic        trap_i = 1'b0, wb_use_mem_i = 1'b0, write_rd_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0, dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic        dmem_req_o, dmem_we_o, mem_busy_o, wb_use_mem_o, write_rd_o, trap_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_o, mem_data_o;
  logic [4:0]  rd_addr_o;
  int nvec = 0, nerr = 0, cur = -1;

  memory_access dut (
    .clk_i(clk), .rst_i(rst_i), .alu_result_i(alu_result_i), .alu_oper2_i(alu_oper2_i),
    .mem_oper_i(mem_oper_i), .trap_i(trap_i), .wb_use_mem_i(wb_use_mem_i),
    .write_rd_i(write_rd_i), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .mem_busy_o(mem_busy_o),
    .alu_result_o(alu_result_o), .mem_data_o(mem_data_o), .wb_use_mem_o(wb_use_mem_o),
    .write_rd_o(write_rd_o), .trap_o(trap_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_oper_t   op;
    logic [31:0] addr, op2, rdata;
    int          dly;
    bit          mis, wr_in;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    bit          e_we;
    logic [31:0] e_wdata, e_data;
    bit          e_wr, e_trap;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL vec %0d %s: got %h want %h", cur, n, a, e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_n = 0, req_n = 0;
    cur = idx;
    @(negedge clk);
    mem_oper_i = v.op; alu_result_i = v.addr; alu_oper2_i = v.op2;
    write_rd_i = v.wr_in; wb_use_mem_i = v.wr_in; rd_addr_i = 5'(idx + 1);
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    if (v.mis) begin
      dmem_gnt_i = 1'b1;
      #1 chk("mis_req", 32'(dmem_req_o), 32'd0);
      chk("mis_busy", 32'(mem_busy_o), 32'd0);
      @(posedge clk);
    end else begin
      for (int k = 0; k <= v.dly; k++) begin
        if (k > 0) @(negedge clk);
        dmem_gnt_i = (k == v.dly);
        #1;
        req_n += int'(dmem_req_o);
        busy_n += int'(mem_busy_o);
        chk("addr", dmem_addr_o, v.e_addr);
        chk("be", 32'(dmem_be_o), 32'(v.e_be));
        chk("we", 32'(dmem_we_o), 32'(v.e_we));
        if (v.e_we) chk("wdata", dmem_wdata_o, v.e_wdata);
        @(posedge clk);
      end
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata;
      #1;
      req_n += int'(dmem_req_o);
      busy_n += int'(mem_busy_o);
      @(posedge clk);
      chk("req_cycles", 32'(req_n), 32'(v.dly + 1));
      chk("busy_cycles", 32'(busy_n), 32'(v.dly + 1));
    end
    @(negedge clk);
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    #1 chk("mem_data", mem_data_o, v.e_data);
    chk("write_rd", 32'(write_rd_o), 32'(v.e_wr));
    chk("trap", 32'(trap_o), 32'(v.e_trap));
    chk("rd_addr", 32'(rd_addr_o), 32'(idx + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{MEM_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vt[1]  = '{MEM_LB,  32'h103, 32'h0,        32'h80112233, 0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    vt[2]  = '{MEM_LBU, 32'h103, 32'h0,        32'h80112233, 1, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'h00000080, 1'b1, 1'b0};
    vt[3]  = '{MEM_SH,  32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 3, 1'b0, 1'b0, 32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0,        1'b0, 1'b0};
    vt[4]  = '{MEM_LW,  32'h101, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vt[5]  = '{MEM_LH,  32'h102, 32'h0,        32'h8001FFFF, 1, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    vt[6]  = '{MEM_LHU, 32'h200, 32'h0,        32'h8001FFFF, 0, 1'b0, 1'b1, 32'h200, 4'b1111, 1'b0, 32'h0,        32'h0000FFFF, 1'b1, 1'b0};
    vt[7]  = '{MEM_SB,  32'h101, 32'h123456A5, 32'hFFFFFFFF, 2, 1'b0, 1'b0, 32'h100, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vt[8]  = '{MEM_SW,  32'h104, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h104, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
    vt[9]  = '{MEM_SH,  32'h101, 32'h0000ABCD, 32'h0,        0, 1'b1, 1'b0, 32'h100, 4'b1111, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1};
    vt[10] = '{MEM_LB,  32'h101, 32'h0,        32'h00007F00, 0, 1'b0, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0,        32'h0000007F, 1'b1, 1'b0};
    vt[11] = '{MEM_LHU, 32'h203, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h200, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vt[12] = '{MEM_LH,  32'h200, 32'h0,        32'h00018000, 0, 1'b0, 1'b1, 32'h200, 4'b1111, 1'b0, 32'h0,        32'hFFFF8000, 1'b1, 1'b0};
    vt[13] = '{MEM_SW,  32'h106, 32'h11111111, 32'h0,        0, 1'b1, 1'b0, 32'h104, 4'b1111, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_busy", 32'(mem_busy_o), 32'd0);
    chk("rst_alu", alu_result_o, 32'd0);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_wr", 32'(write_rd_o), 32'd0);
    chk("rst_trap", 32'(trap_o), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // NOP passes straight through into MEM/WB
    cur = 100;
    @(negedge clk);
    mem_oper_i = MEM_NOP; alu_result_i = 32'h55; write_rd_i = 1'b1; rd_addr_i = 5'd7;
    #1 chk("nop_busy", 32'(mem_busy_o), 32'd0);
    chk("nop_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 chk("nop_alu", alu_result_o, 32'h55);
    chk("nop_rd", 32'(rd_addr_o), 32'd7);
    chk("nop_wr", 32'(write_rd_o), 32'd1);
    chk("nop_data", mem_data_o, 32'd0);

    // LHU completes while stalled: held in DONE, retired once stall drops
    cur = 101;
    mem_oper_i = MEM_LHU; alu_result_i = 32'h202; rd_addr_i = 5'd9; write_rd_i = 1'b1; dmem_gnt_i = 1'b1;
    #1 chk("st_req", 32'(dmem_req_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001FFFF; stall_i = 1'b1;
    #1 chk("st_rv_busy", 32'(mem_busy_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    #1 chk("st_done_req", 32'(dmem_req_o), 32'd0);
    chk("st_done_busy", 32'(mem_busy_o), 32'd0);
    chk("st_hold_rd", 32'(rd_addr_o), 32'd7);
    @(posedge clk);
    @(negedge clk);
    stall_i = 1'b0;
    #1 chk("st_done2_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    #1 chk("st_data", mem_data_o, 32'h00008001);
    chk("st_rd", 32'(rd_addr_o), 32'd9);
    chk("st_wr", 32'(write_rd_o), 32'd1);

    // flush during WAIT_RVALID discards the result
    cur = 102;
    @(negedge clk);
    mem_oper_i = MEM_LW; alu_result_i = 32'h300; rd_addr_i = 5'd5; write_rd_i = 1'b1; dmem_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    #1 chk("fl_busy", 32'(mem_busy_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    #1 chk("fl_wr_cleared", 32'(write_rd_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0; mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    #1 chk("fl_wr", 32'(write_rd_o), 32'd0);
    chk("fl_data", mem_data_o, 32'd0);
    chk("fl_rd", 32'(rd_addr_o), 32'd0);

    // reset while waiting for grant, then a late rvalid
    cur = 103;
    mem_oper_i = MEM_LW; alu_result_i = 32'h400; rd_addr_i = 5'd3; write_rd_i = 1'b1; dmem_gnt_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 chk("rg_req", 32'(dmem_req_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0; mem_oper_i = MEM_NOP; alu_result_i = '0; rd_addr_i = '0; write_rd_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    #1 chk("rg_req0", 32'(dmem_req_o), 32'd0);
    chk("rg_busy0", 32'(mem_busy_o), 32'd0);
    chk("rg_alu", alu_result_o, 32'd0);
    chk("rg_wr", 32'(write_rd_o), 32'd0);
    chk("rg_trap", 32'(trap_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1 chk("rg_late_data", mem_data_o, 32'd0);
    chk("rg_late_busy", 32'(mem_busy_o), 32'd0);
    run_vec(vt[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
